// File: rtl/evm_pkg.sv
// Shared constants for the EVM front-end: candidate count, debounce default,
// FSM state encodings and a small one-hot helper.
package evm_pkg;

    localparam int NUM_CANDIDATES          = 3;
    localparam int NUM_INPUTS              = NUM_CANDIDATES + 1;
    localparam int READY_IDX               = NUM_CANDIDATES;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 16;
    localparam int CNT_W                   = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ARMED  = 2'd1;
    localparam state_t ST_LOCKED = 2'd2;

    function automatic logic is_onehot(input logic [NUM_CANDIDATES-1:0] v);
        logic [NUM_CANDIDATES-1:0] w_lsb_cleared;
        w_lsb_cleared = v & (v - {{(NUM_CANDIDATES-1){1'b0}}, 1'b1});
        return (v != '0) && (w_lsb_cleared == '0);
    endfunction

endpackage

// File: rtl/vote_debounce.sv
// One button path: 2-flop synchronizer, saturating debounce counter and a
// registered rising-edge detector on the debounced level.
module vote_debounce
    import evm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_stable,
    output logic o_rise
);

    localparam logic [CNT_W-1:0] TERM    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_stable_d;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_rise     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= i_raw;
            r_sync2    <= r_sync1;
            // The DEBOUNCE_CYCLES-th consecutive differing sample flips the level
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == TERM) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
            r_stable_d <= r_stable;
            r_rise     <= r_stable & ~r_stable_d;
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = r_rise;

endmodule

// File: rtl/vote_input_conditioner.sv
// Conditions the three vote buttons and the ready button, then arbitrates
// them into single-cycle vote/ready/conflict pulses for the EVM.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for a ready event; vote events are dropped
//   ARMED     | one vote may be accepted; simultaneous/overlapping -> conflict
//   LOCKED    | vote taken; waits for all vote buttons to be released
module vote_input_conditioner
    import evm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CANDIDATES-1:0] raw_vote,
    input  logic                      raw_ready,
    input  logic                      enable,
    output logic [NUM_CANDIDATES-1:0] vote_pulse,
    output logic                      ready_pulse,
    output logic                      conflict,
    output logic                      armed
);

    logic [NUM_INPUTS-1:0]     w_raw;
    logic [NUM_INPUTS-1:0]     w_lvl;
    logic [NUM_INPUTS-1:0]     w_rise;
    logic [NUM_CANDIDATES-1:0] w_vote_lvl;
    logic [NUM_CANDIDATES-1:0] w_vote_ev;
    logic                      w_ready_ev;
    logic                      w_vote_clean;

    state_t                    r_state;
    logic [NUM_CANDIDATES-1:0] r_vote_pulse;
    logic                      r_ready_pulse;
    logic                      r_conflict;

    assign w_raw = {raw_ready, raw_vote};

    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_deb
        vote_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk      (clk),
            .rst      (rst),
            .i_raw    (w_raw[gi]),
            .o_stable (w_lvl[gi]),
            .o_rise   (w_rise[gi])
        );
    end

    assign w_vote_lvl = w_lvl[NUM_CANDIDATES-1:0];
    assign w_vote_ev  = w_rise[NUM_CANDIDATES-1:0];
    assign w_ready_ev = w_rise[READY_IDX] & w_lvl[READY_IDX];

    // A lone edge is only clean if no other button is already held down
    assign w_vote_clean = is_onehot(w_vote_ev) && ((w_vote_lvl & ~w_vote_ev) == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_vote_pulse  <= '0;
            r_ready_pulse <= 1'b0;
            r_conflict    <= 1'b0;
        end else begin
            r_vote_pulse  <= '0;
            r_ready_pulse <= 1'b0;
            r_conflict    <= 1'b0;
            if (!enable) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_ready_ev) begin
                            r_ready_pulse <= 1'b1;
                            r_state       <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (w_vote_ev != '0) begin
                            if (w_vote_clean) begin
                                r_vote_pulse <= w_vote_ev;
                                r_state      <= ST_LOCKED;
                            end else begin
                                r_conflict <= 1'b1;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (w_vote_lvl == '0) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign vote_pulse  = r_vote_pulse & {NUM_CANDIDATES{enable}};
    assign ready_pulse = r_ready_pulse & enable;
    assign conflict    = r_conflict & enable;
    assign armed       = (r_state == ST_ARMED);

endmodule

// File: tb/tb_vote_input_conditioner.sv
// Directed bench for vote_input_conditioner with DEBOUNCE_CYCLES=4: a vector
// table of single-press patterns plus hand sequences for multi-cycle cases.
module tb_vote_input_conditioner;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] raw_vote;
    logic       raw_ready;
    logic       enable;
    logic [2:0] vote_pulse;
    logic       ready_pulse;
    logic       conflict;
    logic       armed;

    always #5 clk = ~clk;

    vote_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .raw_vote    (raw_vote),
        .raw_ready   (raw_ready),
        .enable      (enable),
        .vote_pulse  (vote_pulse),
        .ready_pulse (ready_pulse),
        .conflict    (conflict),
        .armed       (armed)
    );

    int n_pass  = 0;
    int n_total = 0;

    int         acc_vote_cnt  = 0;
    int         acc_conf_cnt  = 0;
    int         acc_ready_cnt = 0;
    logic [2:0] acc_vote      = 3'b000;
    int         viol_cnt      = 0;

    always @(negedge clk) begin
        if (vote_pulse != 3'b000) begin
            acc_vote_cnt = acc_vote_cnt + 1;
            acc_vote     = acc_vote | vote_pulse;
        end
        if (conflict)    acc_conf_cnt  = acc_conf_cnt + 1;
        if (ready_pulse) acc_ready_cnt = acc_ready_cnt + 1;
        if ($countones(vote_pulse) > 1) viol_cnt = viol_cnt + 1;
        if ((vote_pulse != 3'b000) && conflict) viol_cnt = viol_cnt + 1;
        if (!enable && ((vote_pulse != 3'b000) || ready_pulse || conflict)) viol_cnt = viol_cnt + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_acc();
        acc_vote_cnt  = 0;
        acc_conf_cnt  = 0;
        acc_ready_cnt = 0;
        acc_vote      = 3'b000;
    endtask

    task automatic do_reset();
        raw_vote  = 3'b000;
        raw_ready = 1'b0;
        enable    = 1'b1;
        rst       = 1'b1;
        #1;
        check("reset_outputs", int'({vote_pulse, ready_pulse, conflict, armed}), 0);
        tick(3);
        rst = 1'b0;
        tick(1);
        check("post_reset_outputs", int'({vote_pulse, ready_pulse, conflict, armed}), 0);
        clear_acc();
    endtask

    task automatic arm();
        raw_ready = 1'b1;
        tick(10);
        raw_ready = 1'b0;
        tick(8);
    endtask

    typedef struct {
        logic [2:0] pat;
        int         hold;
        logic [2:0] exp_vote;
        int         exp_vote_cnt;
        int         exp_conf_cnt;
        logic       exp_armed;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int first;
        int cnt;
        logic [2:0] val;

        rst       = 1'b1;
        enable    = 1'b0;
        raw_vote  = 3'b000;
        raw_ready = 1'b0;

        vecs[0] = '{3'b001, 8, 3'b001, 1, 0, 1'b0};
        vecs[1] = '{3'b010, 8, 3'b010, 1, 0, 1'b0};
        vecs[2] = '{3'b100, 8, 3'b100, 1, 0, 1'b0};
        vecs[3] = '{3'b101, 8, 3'b000, 0, 1, 1'b1};
        vecs[4] = '{3'b111, 8, 3'b000, 0, 1, 1'b1};
        vecs[5] = '{3'b001, 3, 3'b000, 0, 0, 1'b1};
        vecs[6] = '{3'b100, 4, 3'b100, 1, 0, 1'b0};

        tick(2);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            arm();
            check($sformatf("vec%0d_armed_before", i), int'(armed), 1);
            clear_acc();
            raw_vote = vecs[i].pat;
            tick(vecs[i].hold);
            raw_vote = 3'b000;
            tick(16);
            check($sformatf("vec%0d_vote", i), int'(acc_vote), int'(vecs[i].exp_vote));
            check($sformatf("vec%0d_vote_cnt", i), acc_vote_cnt, vecs[i].exp_vote_cnt);
            check($sformatf("vec%0d_conflict_cnt", i), acc_conf_cnt, vecs[i].exp_conf_cnt);
            check($sformatf("vec%0d_armed_after", i), int'(armed), int'(vecs[i].exp_armed));
        end

        // Exact latency of ready and vote pulses
        do_reset();
        raw_ready = 1'b1;
        first = -1;
        cnt   = 0;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            if (ready_pulse) begin
                cnt++;
                if (first < 0) first = k;
            end
        end
        check("ready_latency", first, 7);
        check("ready_pulse_count", cnt, 1);
        check("armed_after_ready", int'(armed), 1);
        raw_ready = 1'b0;
        tick(8);
        raw_vote = 3'b010;
        first = -1;
        cnt   = 0;
        val   = 3'b000;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            if (vote_pulse != 3'b000) begin
                cnt++;
                if (first < 0) begin
                    first = k;
                    val   = vote_pulse;
                end
            end
        end
        check("vote_latency", first, 7);
        check("vote_value", int'(val), 2);
        check("vote_pulse_count", cnt, 1);
        check("armed_after_vote", int'(armed), 0);
        raw_vote = 3'b000;
        tick(10);

        // Vote held in IDLE is dropped, then a second press while it is held conflicts
        do_reset();
        raw_vote = 3'b001;
        tick(12);
        check("idle_discard_votes", acc_vote_cnt, 0);
        check("idle_discard_armed", int'(armed), 0);
        arm();
        check("overlap_armed_before", int'(armed), 1);
        clear_acc();
        raw_vote = 3'b011;
        tick(12);
        check("overlap_conflict_cnt", acc_conf_cnt, 1);
        check("overlap_vote_cnt", acc_vote_cnt, 0);
        check("overlap_armed_after", int'(armed), 1);
        raw_vote = 3'b000;
        tick(10);

        // Ready ignored while locked, accepted after the vote button is released
        do_reset();
        arm();
        clear_acc();
        raw_vote = 3'b100;
        tick(10);
        check("locked_vote_cnt", acc_vote_cnt, 1);
        check("locked_armed", int'(armed), 0);
        raw_ready = 1'b1;
        tick(10);
        raw_ready = 1'b0;
        tick(8);
        check("locked_ready_ignored", acc_ready_cnt, 0);
        check("locked_still_not_armed", int'(armed), 0);
        raw_vote = 3'b000;
        tick(10);
        check("released_no_ready", acc_ready_cnt, 0);
        clear_acc();
        arm();
        check("rearm_ready_cnt", acc_ready_cnt, 1);
        check("rearm_armed", int'(armed), 1);

        // Enable dropped while armed
        do_reset();
        arm();
        check("en_armed_before", int'(armed), 1);
        enable = 1'b0;
        tick(2);
        check("en_low_armed", int'(armed), 0);
        clear_acc();
        raw_vote = 3'b001;
        tick(12);
        raw_vote = 3'b000;
        tick(8);
        check("en_low_vote_cnt", acc_vote_cnt, 0);
        raw_ready = 1'b1;
        tick(10);
        raw_ready = 1'b0;
        tick(8);
        check("en_low_ready_cnt", acc_ready_cnt, 0);
        check("en_low_armed_after_ready", int'(armed), 0);
        enable = 1'b1;
        tick(4);
        check("en_high_no_rearm", int'(armed), 0);

        // Reset during LOCKED with vote held and a ready press pending
        do_reset();
        arm();
        clear_acc();
        raw_vote = 3'b010;
        tick(10);
        check("rst_locked_vote_cnt", acc_vote_cnt, 1);
        raw_ready = 1'b1;
        tick(3);
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", int'({vote_pulse, ready_pulse, conflict, armed}), 0);
        tick(3);
        rst = 1'b0;
        clear_acc();
        first = -1;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            if (ready_pulse && first < 0) first = k;
        end
        check("rst_release_ready_latency", first, 7);
        check("rst_release_vote_cnt", acc_vote_cnt, 0);
        check("rst_release_conflict_cnt", acc_conf_cnt, 0);
        check("rst_release_armed", int'(armed), 1);
        raw_ready = 1'b0;
        raw_vote  = 3'b000;
        tick(10);

        check("invariants", viol_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
